// File: rtl/morse_transmit_char_pkg.sv
// Shared definitions for the Morse transmitter.
// Holds the character-code width, the Morse length limits, the space code,
// the FSM state encoding and the packed {len, dits_dahs} code type.
// morse_code() turns a pattern written left-to-right (first element in the
// most significant used bit, 1 = dah) into the transmit order, where
// element i sits in dits_dahs[i] and i = 0 is sent first.
package morse_transmit_char_pkg;

  localparam int CHAR_W        = 8;
  localparam int MORSE_LEN_W   = 3;
  localparam int MAX_MORSE_LEN = 5;

  localparam logic [CHAR_W-1:0] CHAR_CODE_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_e;

  typedef struct packed {
    logic [MORSE_LEN_W-1:0]   len;
    logic [MAX_MORSE_LEN-1:0] dits_dahs;
  } morse_code_t;

  // Reverses the low 'len' bits so the table can be written as read aloud.
  function automatic morse_code_t morse_code(input int len,
                                             input logic [MAX_MORSE_LEN-1:0] written);
    morse_code_t code;
    code.len       = MORSE_LEN_W'(len);
    code.dits_dahs = '0;
    for (int i = 0; i < MAX_MORSE_LEN; i++) begin
      if (i < len) begin
        code.dits_dahs[3'(i)] = written[3'(len - 1 - i)];
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/morse_transmit_char_encode.sv
// morse_encode_char: combinational character code -> Morse pattern.
// Ports:
//   char       in  [CHAR_W]         ASCII character code (A-Z, 0-9)
//   len        out [MORSE_LEN_W]    number of elements, 0 when unmapped
//   dits_dahs  out [MAX_MORSE_LEN]  element i in bit i, 1 = dah, bit 0 first
// The table is the inverse of the receiver's recognition table; anything
// it does not list (including space, handled by the top) reports len = 0.
module morse_encode_char
  import morse_transmit_char_pkg::*;
(
  input  logic [CHAR_W-1:0]        char,
  output logic [MORSE_LEN_W-1:0]   len,
  output logic [MAX_MORSE_LEN-1:0] dits_dahs
);

  morse_code_t code;

  always_comb begin
    code = '0;
    case (char)
      8'h41: code = morse_code(2, 5'b00001); // A .-
      8'h42: code = morse_code(4, 5'b01000); // B -...
      8'h43: code = morse_code(4, 5'b01010); // C -.-.
      8'h44: code = morse_code(3, 5'b00100); // D -..
      8'h45: code = morse_code(1, 5'b00000); // E .
      8'h46: code = morse_code(4, 5'b00010); // F ..-.
      8'h47: code = morse_code(3, 5'b00110); // G --.
      8'h48: code = morse_code(4, 5'b00000); // H ....
      8'h49: code = morse_code(2, 5'b00000); // I ..
      8'h4A: code = morse_code(4, 5'b00111); // J .---
      8'h4B: code = morse_code(3, 5'b00101); // K -.-
      8'h4C: code = morse_code(4, 5'b00100); // L .-..
      8'h4D: code = morse_code(2, 5'b00011); // M --
      8'h4E: code = morse_code(2, 5'b00010); // N -.
      8'h4F: code = morse_code(3, 5'b00111); // O ---
      8'h50: code = morse_code(4, 5'b00110); // P .--.
      8'h51: code = morse_code(4, 5'b01101); // Q --.-
      8'h52: code = morse_code(3, 5'b00010); // R .-.
      8'h53: code = morse_code(3, 5'b00000); // S ...
      8'h54: code = morse_code(1, 5'b00001); // T -
      8'h55: code = morse_code(3, 5'b00001); // U ..-
      8'h56: code = morse_code(4, 5'b00001); // V ...-
      8'h57: code = morse_code(3, 5'b00011); // W .--
      8'h58: code = morse_code(4, 5'b01001); // X -..-
      8'h59: code = morse_code(4, 5'b01011); // Y -.--
      8'h5A: code = morse_code(4, 5'b01100); // Z --..
      8'h30: code = morse_code(5, 5'b11111); // 0
      8'h31: code = morse_code(5, 5'b01111); // 1
      8'h32: code = morse_code(5, 5'b00111); // 2
      8'h33: code = morse_code(5, 5'b00011); // 3
      8'h34: code = morse_code(5, 5'b00001); // 4
      8'h35: code = morse_code(5, 5'b00000); // 5
      8'h36: code = morse_code(5, 5'b10000); // 6
      8'h37: code = morse_code(5, 5'b11000); // 7
      8'h38: code = morse_code(5, 5'b11100); // 8
      8'h39: code = morse_code(5, 5'b11110); // 9
      default: code = '0;
    endcase
  end

  assign len       = code.len;
  assign dits_dahs = code.dits_dahs;

endmodule

// File: rtl/morse_transmit_char.sv
// morse_transmit_char: keys one character per valid/ready handshake onto
// the Morse 'signal' line with unit-based mark/gap timing.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   ce           timing enable, one prescaler pulse per high cycle
//   char         character code, char_valid/char_ready handshake
//   signal       keyed output, 1 = mark
//   busy         high in every state but IDLE
//   done         1-cycle pulse in the last cycle of a trailing gap
//   error        1-cycle pulse after accepting an unmapped code
//   tone         sidetone
// Optional feature: define MORSE_TX_SIDETONE_EN to add parameter
// TONE_HALF_PERIOD and a tone divider that toggles 'tone' while keyed;
// otherwise tone is tied to 0.
module morse_transmit_char
  import morse_transmit_char_pkg::*;
#(
  parameter int PULSES_PER_UNIT = 10,
  parameter int DIT_UNITS       = 1,
  parameter int DAH_UNITS       = 3,
  parameter int PAUSE_UNITS     = 1,
  parameter int CHAR_UNITS      = 3,
  parameter int WORD_UNITS      = 7,
  parameter int CNT_W           = 16
`ifdef MORSE_TX_SIDETONE_EN
  ,
  parameter int TONE_HALF_PERIOD = 25000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [CHAR_W-1:0] char,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              signal,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              tone
);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         pre_q, pre_d;
  logic [CNT_W-1:0]         unit_q, unit_d;
  logic [CNT_W-1:0]         unit_last;
  logic [MORSE_LEN_W-1:0]   idx_q, idx_d;
  logic [MORSE_LEN_W-1:0]   len_q, len_d;
  logic [MAX_MORSE_LEN-1:0] pat_q, pat_d;
  logic                     signal_q, signal_d;
  logic                     error_q, error_d;

  logic [MORSE_LEN_W-1:0]   enc_len;
  logic [MAX_MORSE_LEN-1:0] enc_pat;
  logic                     tick;
  logic                     interval_done;
  logic                     accept;

  morse_encode_char u_encode (
    .char      (char),
    .len       (enc_len),
    .dits_dahs (enc_pat)
  );

  // Last unit index of the interval the current state is timing.
  always_comb begin
    unit_last = '0;
    case (state_q)
      ST_MARK:     unit_last = pat_q[idx_q] ? CNT_W'(DAH_UNITS - 1) : CNT_W'(DIT_UNITS - 1);
      ST_GAP:      unit_last = CNT_W'(PAUSE_UNITS - 1);
      ST_CHAR_GAP: unit_last = CNT_W'(CHAR_UNITS - 1);
      ST_WORD_GAP: unit_last = CNT_W'(WORD_UNITS - CHAR_UNITS - 1);
      default:     unit_last = '0;
    endcase
  end

  assign tick          = ce && (pre_q == CNT_W'(PULSES_PER_UNIT - 1));
  assign interval_done = tick && (unit_q == unit_last);

  // The final cycle of a trailing gap doubles as an acceptance slot, so a
  // waiting character follows with no extra idle cycle between them.
  assign done       = ((state_q == ST_CHAR_GAP) || (state_q == ST_WORD_GAP)) && interval_done;
  assign char_ready = (state_q == ST_IDLE) || done;
  assign accept     = char_valid && char_ready;
  assign busy       = (state_q != ST_IDLE);
  assign signal     = signal_q;
  assign error      = error_q;

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    unit_d   = unit_q;
    idx_d    = idx_q;
    len_d    = len_q;
    pat_d    = pat_q;
    signal_d = signal_q;
    error_d  = 1'b0;

    if (ce) begin
      if (tick) begin
        pre_d  = '0;
        unit_d = unit_q + CNT_W'(1);
      end else begin
        pre_d = pre_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        pre_d  = '0;
        unit_d = '0;
      end
      ST_MARK: begin
        if (interval_done) begin
          pre_d    = '0;
          unit_d   = '0;
          signal_d = 1'b0;
          if ((idx_q + MORSE_LEN_W'(1)) < len_q) begin
            state_d = ST_GAP;
            idx_d   = idx_q + MORSE_LEN_W'(1);
          end else begin
            state_d = ST_CHAR_GAP;
          end
        end
      end
      ST_GAP: begin
        if (interval_done) begin
          pre_d    = '0;
          unit_d   = '0;
          signal_d = 1'b1;
          state_d  = ST_MARK;
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (interval_done) begin
          pre_d   = '0;
          unit_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        signal_d = 1'b0;
      end
    endcase

    // Acceptance wins over gap completion and restarts all timing.
    if (accept) begin
      pre_d  = '0;
      unit_d = '0;
      idx_d  = '0;
      len_d  = enc_len;
      pat_d  = enc_pat;
      if (char == CHAR_CODE_SPACE) begin
        state_d  = ST_WORD_GAP;
        signal_d = 1'b0;
      end else if (enc_len == '0) begin
        state_d  = ST_IDLE;
        signal_d = 1'b0;
        error_d  = 1'b1;
      end else begin
        state_d  = ST_MARK;
        signal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      unit_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      signal_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      unit_q   <= unit_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      signal_q <= signal_d;
      error_q  <= error_d;
    end
  end

`ifdef MORSE_TX_SIDETONE_EN
  localparam int TONE_W = (TONE_HALF_PERIOD > 1) ? $clog2(TONE_HALF_PERIOD) : 1;

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;

  // Divider runs only while keyed; silence parks it at zero.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (!signal_q) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (tone_cnt_q == TONE_W'(TONE_HALF_PERIOD - 1)) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end else begin
      tone_cnt_d = tone_cnt_q + TONE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign tone = tone_q;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_transmit_char.sv
// Directed self-checking bench for morse_transmit_char with
// PULSES_PER_UNIT = 2; inputs change on the falling edge and outputs are
// observed 1 time unit later, inside the same clock cycle.
module tb_morse_transmit_char;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       signal;
  logic       busy;
  logic       done;
  logic       error;
  logic       tone;

  int pass_count  = 0;
  int check_count = 0;

  morse_transmit_char #(
    .PULSES_PER_UNIT (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .char       (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .signal     (signal),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .tone       (tone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic rst_v, input logic ce_v,
                               input logic valid_v, input logic [7:0] ch);
    @(negedge clk);
    rst_n      = rst_v;
    ce         = ce_v;
    char_valid = valid_v;
    char_in    = ch;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    check_count++;
    assert (observed === expected) pass_count = pass_count + 1;
    else $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
  endtask

  // Present a character for one cycle; it must be taken immediately.
  task automatic acceptChar(input string tag, input logic [7:0] ch);
    applyStimulus(1'b1, 1'b1, 1'b1, ch);
    checkOutput({tag, " char_ready"}, char_ready, 1'b1);
    checkOutput({tag, " signal before"}, signal, 1'b0);
  endtask

  // n cycles of a constant signal level while busy; done only on the last.
  task automatic runExpect(input string tag, input logic ce_v, input logic exp_sig,
                           input int n, input logic exp_done_last);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, ce_v, 1'b0, 8'h00);
      checkOutput($sformatf("%s signal c%0d", tag, i), signal, exp_sig);
      checkOutput($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
      checkOutput($sformatf("%s done c%0d", tag, i), done, (i == n - 1) ? exp_done_last : 1'b0);
    end
  endtask

  task automatic checkIdle(input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput({tag, " char_ready"}, char_ready, 1'b1);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " signal"}, signal, 1'b0);
    checkOutput({tag, " done"}, done, 1'b0);
  endtask

  initial begin
    logic [16:0] ce_pat;

    rst_n      = 1'b0;
    ce         = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;

    // Reset state
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("reset signal", signal, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset error", error, 1'b0);
    checkOutput("reset tone", tone, 1'b0);
    checkOutput("reset char_ready", char_ready, 1'b1);

    // 'E': high 2, low 6 with done on the 6th low cycle
    acceptChar("E", 8'h45);
    runExpect("E mark", 1'b1, 1'b1, 2, 1'b0);
    checkOutput("E tone", tone, 1'b0);
    runExpect("E gap", 1'b1, 1'b0, 6, 1'b1);
    checkIdle("E end");

    // 'A': high 2, low 2, high 6, low 6
    acceptChar("A", 8'h41);
    runExpect("A dit", 1'b1, 1'b1, 2, 1'b0);
    runExpect("A pause", 1'b1, 1'b0, 2, 1'b0);
    runExpect("A dah", 1'b1, 1'b1, 6, 1'b0);
    runExpect("A gap", 1'b1, 1'b0, 6, 1'b1);
    checkIdle("A end");

    // Space alone: 8 cycles of silence, done on the last
    acceptChar("SP", 8'h20);
    runExpect("SP gap", 1'b1, 1'b0, 8, 1'b1);
    checkIdle("SP end");

    // 'E' then space back to back: 6 + 8 = 14 cycles of silence
    acceptChar("ESP", 8'h45);
    runExpect("ESP mark", 1'b1, 1'b1, 2, 1'b0);
    runExpect("ESP gap", 1'b1, 1'b0, 5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h20);
    checkOutput("ESP handoff done", done, 1'b1);
    checkOutput("ESP handoff char_ready", char_ready, 1'b1);
    checkOutput("ESP handoff signal", signal, 1'b0);
    runExpect("ESP word", 1'b1, 1'b0, 8, 1'b1);
    checkIdle("ESP end");

    // Unmapped code '#': error pulse, no mark
    acceptChar("BAD", 8'h23);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("BAD error", error, 1'b1);
    checkOutput("BAD char_ready", char_ready, 1'b1);
    checkOutput("BAD signal", signal, 1'b0);
    checkOutput("BAD busy", busy, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("BAD error clear", error, 1'b0);
    checkOutput("BAD signal after", signal, 1'b0);
    checkOutput("BAD done", done, 1'b0);

    // 'T' with ce at 50% duty: 6 pulses -> 12 cycles of mark
    acceptChar("T50", 8'h54);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, (i % 2) == 1, 1'b0, 8'h00);
      checkOutput($sformatf("T50 mark c%0d", i), signal, 1'b1);
    end
    runExpect("T50 gap", 1'b1, 1'b0, 6, 1'b1);
    checkIdle("T50 end");

    // 'T' with 5 extra ce=0 cycles mid-mark: 17 cycles of mark
    ce_pat = 17'b1010101_0_00000_1010;
    acceptChar("THOLD", 8'h54);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, ce_pat[i], 1'b0, 8'h00);
      checkOutput($sformatf("THOLD mark c%0d", i), signal, 1'b1);
    end
    runExpect("THOLD gap", 1'b1, 1'b0, 6, 1'b1);
    checkIdle("THOLD end");

    // Reset in the middle of the dah of 'A'
    acceptChar("ARST", 8'h41);
    runExpect("ARST dit", 1'b1, 1'b1, 2, 1'b0);
    runExpect("ARST pause", 1'b1, 1'b0, 2, 1'b0);
    runExpect("ARST dah", 1'b1, 1'b1, 3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("ARST signal", signal, 1'b0);
    checkOutput("ARST busy", busy, 1'b0);
    checkOutput("ARST char_ready", char_ready, 1'b1);
    checkOutput("ARST done", done, 1'b0);

    // 'E' after reset must time exactly like the first one
    acceptChar("E2", 8'h45);
    runExpect("E2 mark", 1'b1, 1'b1, 2, 1'b0);
    runExpect("E2 gap", 1'b1, 1'b0, 6, 1'b1);
    checkIdle("E2 end");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
